alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Control sequencer for a 32-bit load/store datapath.
// It decodes ir[31:27] and steps IDLE/T0..T7/HALT, driving Moore datapath strobes.
module alu_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic [4:0]       alu_op,
  output logic             pc_out,
  output logic             pc_in,
  output logic             inc_pc,
  output logic             mar_in,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mdr_in,
  output logic             mdr_out,
  output logic             ir_in,
  output logic             y_in,
  output logic             z_in,
  output logic             zlo_out,
  output logic             zhi_out,
  output logic             hi_in,
  output logic             lo_in,
  output logic             gra,
  output logic             grb,
  output logic             grc,
  output logic             r_in,
  output logic             r_out,
  output logic             ba_out,
  output logic             c_out,
  output logic             busy,
  output logic             instr_done,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE, C_IMM, C_MULDIV, C_NEGNOT, C_LOAD, C_LOADI, C_STORE, C_HALT, C_ILLEGAL
  } cls_t;

  state_t           state_q, state_d;
  state_t           next_instr;
  cls_t             cls;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             unused_ir;

  // Register fields are consumed by the datapath through gra/grb/grc, not here.
  assign unused_ir = ^ir[26:0];

  assign alu_op      = ir[31:27];
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted      = (state_q == S_HALT);
  assign instr_count = cnt_q;
  assign cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, instr_done};
  assign next_instr  = run ? S_T0 : S_IDLE;

  always_comb begin
    cls = C_ILLEGAL;
    case (alu_op) inside
      5'd0:           cls = C_LOAD;
      5'd1:           cls = C_LOADI;
      5'd2:           cls = C_STORE;
      [5'd3:5'd11]:   cls = C_RTYPE;
      [5'd12:5'd14]:  cls = C_IMM;
      [5'd15:5'd16]:  cls = C_MULDIV;
      [5'd17:5'd18]:  cls = C_NEGNOT;
      5'd27:          cls = C_HALT;
      default:        cls = C_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    {pc_out, pc_in, inc_pc, mar_in, mem_read, mem_write, mdr_in, mdr_out,
     ir_in, y_in, z_in, zlo_out, zhi_out, hi_in, lo_in, gra, grb, grc,
     r_in, r_out, ba_out, c_out} = '0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    state_d    = state_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        {pc_out, mar_in, inc_pc, z_in} = '1;
        state_d = S_T1;
      end
      S_T1: begin
        {zlo_out, pc_in, mem_read, mdr_in} = '1;
        if (mem_ready) state_d = S_T2;
      end
      S_T2: begin
        {mdr_out, ir_in} = '1;
        state_d = S_T3;
      end
      S_T3: begin
        state_d = S_T4;
        case (cls)
          C_RTYPE, C_IMM:             {grb, r_out, y_in} = '1;
          C_MULDIV:                   {gra, r_out, y_in} = '1;
          C_NEGNOT:                   {grb, r_out, z_in} = '1;
          C_LOAD, C_LOADI, C_STORE:   {grb, ba_out, y_in} = '1;
          C_HALT:                     state_d = S_HALT;
          default: begin
            illegal = 1'b1;
            state_d = next_instr;
          end
        endcase
      end
      S_T4: begin
        state_d = S_T5;
        case (cls)
          C_RTYPE:                    {grc, r_out, z_in} = '1;
          C_IMM, C_LOAD, C_LOADI, C_STORE: {c_out, z_in} = '1;
          C_MULDIV:                   {grb, r_out, z_in} = '1;
          C_NEGNOT: begin
            {zlo_out, gra, r_in, instr_done} = '1;
            state_d = next_instr;
          end
          // ir changed under us mid-instruction: drop back to fetch quietly.
          default:                    state_d = next_instr;
        endcase
      end
      S_T5: begin
        state_d = S_T6;
        case (cls)
          C_RTYPE, C_IMM, C_LOADI: begin
            {zlo_out, gra, r_in, instr_done} = '1;
            state_d = next_instr;
          end
          C_MULDIV:                   {zlo_out, lo_in} = '1;
          C_LOAD, C_STORE:            {zlo_out, mar_in} = '1;
          default:                    state_d = next_instr;
        endcase
      end
      S_T6: begin
        state_d = S_T7;
        case (cls)
          C_MULDIV: begin
            {zhi_out, hi_in, instr_done} = '1;
            state_d = next_instr;
          end
          C_LOAD: begin
            {mem_read, mdr_in} = '1;
            if (!mem_ready) state_d = S_T6;
          end
          C_STORE:                    {gra, r_out, mdr_in} = '1;
          default:                    state_d = next_instr;
        endcase
      end
      S_T7: begin
        state_d = next_instr;
        case (cls)
          C_LOAD:  {mdr_out, gra, r_in, instr_done} = '1;
          C_STORE: begin
            mem_write  = 1'b1;
            instr_done = mem_ready;
            if (!mem_ready) state_d = S_T7;
          end
          default: ;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: opcode vector table plus hand sequences for waits,
// halt, illegal, reset abort and counter wrap (via a narrow-counter twin).
module tb_alu_sequencer;

  localparam int I_PC_OUT = 21, I_MEM_READ = 17, I_MEM_WRITE = 16;
  localparam logic [21:0] M_PC_OUT = 22'd1 << 21, M_PC_IN = 22'd1 << 20, M_INC_PC = 22'd1 << 19;
  localparam logic [21:0] M_MAR_IN = 22'd1 << 18, M_MEM_READ = 22'd1 << 17, M_MEM_WRITE = 22'd1 << 16;
  localparam logic [21:0] M_MDR_IN = 22'd1 << 15, M_MDR_OUT = 22'd1 << 14, M_IR_IN = 22'd1 << 13;
  localparam logic [21:0] M_Y_IN = 22'd1 << 12, M_Z_IN = 22'd1 << 11, M_ZLO = 22'd1 << 10;
  localparam logic [21:0] M_ZHI = 22'd1 << 9, M_HI_IN = 22'd1 << 8, M_LO_IN = 22'd1 << 7;
  localparam logic [21:0] M_GRA = 22'd1 << 6, M_GRB = 22'd1 << 5, M_GRC = 22'd1 << 4;
  localparam logic [21:0] M_R_IN = 22'd1 << 3, M_R_OUT = 22'd1 << 2, M_BA_OUT = 22'd1 << 1;
  localparam logic [21:0] M_C_OUT = 22'd1;

  localparam logic [21:0] R_T4   = M_GRC | M_R_OUT | M_Z_IN;
  localparam logic [21:0] IMM_T4 = M_C_OUT | M_Z_IN;
  localparam logic [21:0] MD_T4  = M_GRB | M_R_OUT | M_Z_IN;
  localparam logic [21:0] WB     = M_ZLO | M_GRA | M_R_IN;
  localparam logic [21:0] MD_FIN = M_ZHI | M_HI_IN;
  localparam logic [21:0] LD_FIN = M_MDR_OUT | M_GRA | M_R_IN;
  localparam logic [21:0] ST_FIN = M_MEM_WRITE;
  localparam logic [21:0] F_T0   = M_PC_OUT | M_MAR_IN | M_INC_PC | M_Z_IN;
  localparam logic [21:0] F_T1   = M_ZLO | M_PC_IN | M_MEM_READ | M_MDR_IN;
  localparam logic [21:0] F_T2   = M_MDR_OUT | M_IR_IN;

  typedef struct {
    string       nm;
    int          cyc;
    logic [21:0] t4;
    logic        chk_t4;
    logic [21:0] fin;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    int          cyc;
    logic [21:0] t4;
    logic [21:0] fin;
    logic        ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        clr, run, mem_ready;
  logic [31:0] ir;
  logic [4:0]  alu_op;
  logic [21:0] strb;
  logic        busy, instr_done, illegal, halted;
  logic [15:0] instr_count;
  logic [2:0]  cnt_s;
  logic [21:0] unused_s_strb;
  logic [4:0]  unused_s_op;
  logic [3:0]  unused_s_flags;

  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  int   mon_cyc = 0;
  exp_t exp_q[$];
  logic [21:0] trace [64];
  vec_t vt [23];

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_ready(mem_ready), .alu_op(alu_op),
    .pc_out(strb[21]), .pc_in(strb[20]), .inc_pc(strb[19]), .mar_in(strb[18]),
    .mem_read(strb[17]), .mem_write(strb[16]), .mdr_in(strb[15]), .mdr_out(strb[14]),
    .ir_in(strb[13]), .y_in(strb[12]), .z_in(strb[11]), .zlo_out(strb[10]),
    .zhi_out(strb[9]), .hi_in(strb[8]), .lo_in(strb[7]), .gra(strb[6]), .grb(strb[5]),
    .grc(strb[4]), .r_in(strb[3]), .r_out(strb[2]), .ba_out(strb[1]), .c_out(strb[0]),
    .busy(busy), .instr_done(instr_done), .illegal(illegal), .halted(halted),
    .instr_count(instr_count)
  );

  alu_sequencer #(.CNT_W(3)) dut_s (
    .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_ready(mem_ready), .alu_op(unused_s_op),
    .pc_out(unused_s_strb[21]), .pc_in(unused_s_strb[20]), .inc_pc(unused_s_strb[19]),
    .mar_in(unused_s_strb[18]), .mem_read(unused_s_strb[17]), .mem_write(unused_s_strb[16]),
    .mdr_in(unused_s_strb[15]), .mdr_out(unused_s_strb[14]), .ir_in(unused_s_strb[13]),
    .y_in(unused_s_strb[12]), .z_in(unused_s_strb[11]), .zlo_out(unused_s_strb[10]),
    .zhi_out(unused_s_strb[9]), .hi_in(unused_s_strb[8]), .lo_in(unused_s_strb[7]),
    .gra(unused_s_strb[6]), .grb(unused_s_strb[5]), .grc(unused_s_strb[4]),
    .r_in(unused_s_strb[3]), .r_out(unused_s_strb[2]), .ba_out(unused_s_strb[1]),
    .c_out(unused_s_strb[0]), .busy(unused_s_flags[3]), .instr_done(unused_s_flags[2]),
    .illegal(unused_s_flags[1]), .halted(unused_s_flags[0]), .instr_count(cnt_s)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic setv(input int i, input logic [4:0] op, input int cyc,
                      input logic [21:0] t4, input logic [21:0] fin, input logic ill);
    vt[i].op = op; vt[i].cyc = cyc; vt[i].t4 = t4; vt[i].fin = fin; vt[i].ill = ill;
  endtask

  // Scoreboard side: pops one expectation per completed/illegal instruction.
  initial forever begin
    @(negedge clk);
    if (!clr || !busy) begin
      mon_cyc = 0;
    end else begin
      if (mon_cyc + 1 < 64) trace[mon_cyc+1] = strb;
      if (instr_done || illegal) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_end", {instr_done, illegal}, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk({e.nm, "_cycles"}, mon_cyc + 1, e.cyc);
          chk({e.nm, "_final"}, strb, e.fin);
          chk({e.nm, "_flags"}, {illegal, instr_done}, {e.ill, !e.ill});
          if (e.chk_t4) chk({e.nm, "_t4"}, trace[5], e.t4);
        end
        mon_cyc = 0;
      end else begin
        mon_cyc = mon_cyc + 1;
      end
    end
  end

  task automatic exec(input string nm, input logic [4:0] op, input int w1, input int w2,
                      input int cyc, input logic [21:0] t4, input logic [21:0] fin,
                      input logic ill, output int nrd);
    exp_t e;
    logic tied;
    int   seg, sc;
    bit   seen;
    tied = (w1 == 0 && w2 == 0);
    e.nm = nm; e.cyc = cyc; e.t4 = t4; e.chk_t4 = (w1 == 0) && !ill; e.fin = fin; e.ill = ill;
    exp_q.push_back(e);
    nrd = 0; seg = 0; sc = 0; seen = 0;
    @(posedge clk); #1;
    ir = {op, 27'h1234567};
    run = 1'b1;
    mem_ready = tied;
    #1 chk({nm, "_alu_op"}, alu_op, op);
    for (int k = 0; k < 64 && !seen; k++) begin
      @(posedge clk); #1;
      run = 1'b0;
      if (strb[I_MEM_READ]) nrd++;
      if (strb[I_MEM_READ] || strb[I_MEM_WRITE]) begin
        sc++;
        mem_ready = (sc > ((seg == 0) ? w1 : w2));
      end else begin
        if (sc > 0) begin seg++; sc = 0; end
        mem_ready = tied;
      end
      #1 seen = instr_done || illegal;
    end
    if (!seen) begin
      chk({nm, "_timeout"}, 0, 1);
      exp_q.delete();
    end
    @(posedge clk); #1;
    if (!ill) exp_cnt++;
    chk({nm, "_count"}, instr_count, exp_cnt[15:0]);
    chk({nm, "_count3"}, cnt_s, exp_cnt % 8);
    chk({nm, "_idle"}, busy, 0);
    mem_ready = 1'b1;
  endtask

  initial begin
    int nrd;
    int bad;
    bit found;
    exp_t e;

    setv(0, 5'd0, 8, IMM_T4, LD_FIN, 0);
    setv(1, 5'd1, 6, IMM_T4, WB, 0);
    setv(2, 5'd2, 8, IMM_T4, ST_FIN, 0);
    setv(3, 5'd3, 6, R_T4, WB, 0);
    setv(4, 5'd4, 6, R_T4, WB, 0);
    setv(5, 5'd5, 6, R_T4, WB, 0);
    setv(6, 5'd6, 6, R_T4, WB, 0);
    setv(7, 5'd7, 6, R_T4, WB, 0);
    setv(8, 5'd8, 6, R_T4, WB, 0);
    setv(9, 5'd9, 6, R_T4, WB, 0);
    setv(10, 5'd10, 6, R_T4, WB, 0);
    setv(11, 5'd11, 6, R_T4, WB, 0);
    setv(12, 5'd12, 6, IMM_T4, WB, 0);
    setv(13, 5'd13, 6, IMM_T4, WB, 0);
    setv(14, 5'd14, 6, IMM_T4, WB, 0);
    setv(15, 5'd15, 7, MD_T4, MD_FIN, 0);
    setv(16, 5'd16, 7, MD_T4, MD_FIN, 0);
    setv(17, 5'd17, 5, WB, WB, 0);
    setv(18, 5'd18, 5, WB, WB, 0);
    setv(19, 5'd19, 4, '0, '0, 1);
    setv(20, 5'd26, 4, '0, '0, 1);
    setv(21, 5'd28, 4, '0, '0, 1);
    setv(22, 5'd31, 4, '0, '0, 1);

    clr = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = '0;
    #3;
    chk("reset_async", {strb, busy, instr_done, illegal, halted}, 0);
    chk("reset_count", instr_count, 0);
    @(posedge clk); #1;
    run = 1'b1;
    #1 chk("reset_hold", {strb, busy, halted}, 0);
    run = 1'b0;
    clr = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("idle_no_run", busy, 0);

    foreach (vt[i])
      exec($sformatf("op%0d", vt[i].op), vt[i].op, 0, 0, vt[i].cyc, vt[i].t4, vt[i].fin,
           vt[i].ill, nrd);

    exec("add", 5'd3, 0, 0, 6, R_T4, WB, 0, nrd);
    chk("fetch_t0", trace[1], F_T0);
    chk("fetch_t1", trace[2], F_T1);
    chk("fetch_t2", trace[3], F_T2);
    chk("add_t3", trace[4], M_GRB | M_R_OUT | M_Y_IN);

    exec("mul", 5'd15, 0, 0, 7, MD_T4, MD_FIN, 0, nrd);
    chk("mul_t3", trace[4], M_GRA | M_R_OUT | M_Y_IN);
    chk("mul_t5", trace[6], M_ZLO | M_LO_IN);

    exec("load_wait", 5'd0, 3, 2, 13, IMM_T4, LD_FIN, 0, nrd);
    chk("load_rd_cycles", nrd, 7);
    chk("load_t6", trace[11], M_MEM_READ | M_MDR_IN);
    exec("store_wait", 5'd2, 1, 2, 11, IMM_T4, ST_FIN, 0, nrd);
    chk("store_t7_wait", trace[9], M_MEM_WRITE);

    // Illegal with run held: the very next cycle must be a fresh fetch.
    e.nm = "ill_b2b"; e.cyc = 4; e.t4 = '0; e.chk_t4 = 0; e.fin = '0; e.ill = 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    ir = {5'b10101, 27'h0}; run = 1'b1; mem_ready = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #2;
      found = illegal;
    end
    chk("ill_seen", found, 1);
    @(posedge clk); #1;
    chk("ill_next_t0", strb, F_T0);
    chk("ill_count", instr_count, exp_cnt[15:0]);
    run = 1'b0;
    ir = {5'd3, 27'h0};
    e.nm = "add_after_ill"; e.cyc = 6; e.t4 = R_T4; e.chk_t4 = 1; e.fin = WB; e.ill = 0;
    exp_q.push_back(e);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #2;
      found = instr_done;
    end
    chk("add_after_ill_done", found, 1);
    @(posedge clk); #1;
    exp_cnt++;
    chk("add_after_ill_count", instr_count, exp_cnt[15:0]);

    // Reset in the middle of sub's T4 abandons it at once.
    @(posedge clk); #1;
    ir = {5'd4, 27'h0}; run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("sub_in_t4", strb, R_T4);
    #1 clr = 1'b0;
    #1;
    chk("abort_outputs", {strb, busy, instr_done, illegal, halted}, 0);
    chk("abort_count", instr_count, 0);
    chk("abort_count3", cnt_s, 0);
    exp_q.delete();
    exp_cnt = 0;
    @(posedge clk); #1;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("post_reset_idle", busy, 0);

    for (int i = 0; i < 7; i++) exec("add_fill", 5'd3, 0, 0, 6, R_T4, WB, 0, nrd);
    chk("count3_at_max", cnt_s, 7);
    exec("add_wrap", 5'd3, 0, 0, 6, R_T4, WB, 0, nrd);
    chk("count3_wrapped", cnt_s, 0);

    // Halt: sticks with run high until reset.
    @(posedge clk); #1;
    ir = {5'd27, 27'h0}; run = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("halt_entered", {halted, busy}, 2'b10);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (!halted || busy || instr_count != exp_cnt[15:0]) bad++;
    end
    chk("halt_hold", bad, 0);
    #2 clr = 1'b0;
    #1 chk("halt_exit", {halted, busy, instr_count}, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
